// File: rtl/genius_ctrl_param.sv
// Genius (Simon) game controller: setup, playback, user entry, compare,
// round advance and result, with round counter, timeout and win/lose flags.
module genius_ctrl_param #(
    parameter int MAX_ROUNDS  = 16,
    parameter int ROUND_W     = 5,
    parameter int TIMEOUT_CYC = 200,
    parameter int TIMEOUT_W   = 8
) (
    input  logic               clock,
    input  logic               reset_i,
    input  logic               enter_i,
    input  logic [1:0]         level_i,
    input  logic               end_FPGA_i,
    input  logic               end_User_i,
    input  logic               key_i,
    input  logic               match_i,
    output logic               R1_o,
    output logic               R2_o,
    output logic               E1_o,
    output logic               E2_o,
    output logic               E3_o,
    output logic               E4_o,
    output logic               SEL_o,
    output logic [ROUND_W-1:0] round_o,
    output logic               win_o,
    output logic               lose_o,
    output logic [2:0]         state_o
);

    typedef enum logic [2:0] {
        INIT       = 3'd0,
        SETUP      = 3'd1,
        PLAY_FPGA  = 3'd2,
        PLAY_USER  = 3'd3,
        CHECK      = 3'd4,
        NEXT_ROUND = 3'd5,
        RESULT     = 3'd6
    } state_t;

    state_t               state_q, state_d;
    logic [ROUND_W-1:0]   round_q, round_d;
    logic                 win_q, win_d;
    logic                 lose_q, lose_d;
    logic [1:0]           level_q, level_d;
    logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
    logic                 enter_q;
    logic                 enter_rise;
    logic [31:0]          t_shift;
    logic [TIMEOUT_W-1:0] tmo_load;

    assign enter_rise = enter_i & ~enter_q;

    // Harder levels halve the entry window, but never below one cycle.
    always_comb begin
        t_shift  = 32'(TIMEOUT_CYC) >> level_q;
        tmo_load = (t_shift == 32'd0) ? TIMEOUT_W'(1)
                                      : t_shift[TIMEOUT_W-1:0];
    end

    always_ff @(posedge clock or posedge reset_i) begin
        if (reset_i) begin
            state_q <= INIT;
            round_q <= '0;
            win_q   <= 1'b0;
            lose_q  <= 1'b0;
            level_q <= 2'd0;
            tmo_q   <= '0;
            enter_q <= 1'b1;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            win_q   <= win_d;
            lose_q  <= lose_d;
            level_q <= level_d;
            tmo_q   <= tmo_d;
            enter_q <= enter_i;
        end
    end

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        win_d   = win_q;
        lose_d  = lose_q;
        level_d = level_q;
        tmo_d   = tmo_q;
        unique case (state_q)
            INIT: begin
                state_d = SETUP;
            end
            SETUP: begin
                if (enter_rise) begin
                    state_d = PLAY_FPGA;
                    level_d = level_i;
                    round_d = ROUND_W'(1);
                end
            end
            PLAY_FPGA: begin
                if (end_FPGA_i) begin
                    state_d = PLAY_USER;
                    tmo_d   = tmo_load;
                end
            end
            PLAY_USER: begin
                if (end_User_i) begin
                    state_d = CHECK;
                    tmo_d   = '0;
                end else if (tmo_q == '0) begin
                    state_d = RESULT;
                    lose_d  = 1'b1;
                end else if (key_i) begin
                    tmo_d = tmo_load;
                end else begin
                    tmo_d = tmo_q - TIMEOUT_W'(1);
                end
            end
            CHECK: begin
                if (match_i) begin
                    state_d = NEXT_ROUND;
                end else begin
                    state_d = RESULT;
                    lose_d  = 1'b1;
                end
            end
            NEXT_ROUND: begin
                if (round_q == ROUND_W'(MAX_ROUNDS)) begin
                    state_d = RESULT;
                    win_d   = 1'b1;
                end else begin
                    state_d = PLAY_FPGA;
                    round_d = round_q + ROUND_W'(1);
                end
            end
            RESULT: begin
                if (enter_rise) begin
                    state_d = INIT;
                    round_d = '0;
                    win_d   = 1'b0;
                    lose_d  = 1'b0;
                end
            end
            default: begin
                state_d = INIT;
                round_d = '0;
                win_d   = 1'b0;
                lose_d  = 1'b0;
                tmo_d   = '0;
            end
        endcase
    end

    always_comb begin
        R1_o  = 1'b0;
        R2_o  = 1'b0;
        E1_o  = 1'b0;
        E2_o  = 1'b0;
        E3_o  = 1'b0;
        E4_o  = 1'b0;
        SEL_o = 1'b0;
        unique case (state_q)
            INIT: begin
                R1_o = 1'b1;
                R2_o = 1'b1;
            end
            SETUP:      E1_o  = 1'b1;
            PLAY_FPGA:  E3_o  = 1'b1;
            PLAY_USER:  E2_o  = 1'b1;
            CHECK:      E4_o  = 1'b1;
            NEXT_ROUND: R2_o  = 1'b1;
            RESULT:     SEL_o = 1'b1;
            default: ;
        endcase
    end

    assign round_o = round_q;
    assign win_o   = win_q;
    assign lose_o  = lose_q;
    assign state_o = state_q;

endmodule
